centurion_bus_responder: RTL and testbench
==========================================

# centurion_bus_responder

Slave side of the CPU6 memory bus: decodes the 16-bit address driven by the CPU, serves a zero-wait-state RAM, and exposes a console MUX port (status + data registers) with a transmit FIFO and a receive holding register. It sits between the CPU6 bus pins (`addressBus`, `dataOutBus`, `writeEnBus`, `dataInBus`) and an external byte-serial console (UART or testbench).

## Interface
- `RAM_WORDS`, 4096: RAM bytes, mapped from 0x0000 upward; power of two, max 0x8000.
- `TX_DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `clock` in 1: single clock, same as CPU6.
- `reset` in 1: synchronous, active-high.
- `addressBus` in 16: CPU address.
- `dataOutBus` in 8: CPU write data.
- `writeEnBus` in 1: write strobe, one clock per write.
- `dataInBus` out 8: read data to CPU, combinational from address.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_data` out 8: TX FIFO head.
- `tx_ready` in 1: console accepts `tx_data` when `tx_valid & tx_ready` at a clock edge.
- `rx_valid` in 1: one-clock pulse, received byte on `rx_data`.
- `rx_data` in 8: received byte.

## Operation
- Map: RAM at 0x0000..RAM_WORDS-1; STATUS at 0xF200; DATA at 0xF201; everything else unmapped.
- RAM read: `dataInBus` = mem[addr] combinationally. Write: mem[addr] <= `dataOutBus` at edge when `writeEnBus`. RAM is not cleared by reset.
- Unmapped read returns 0xFF; unmapped write ignored.
- STATUS read: bit0 RX_FULL, bit1 TX_NOT_FULL, bit2 TX_OVERFLOW, bit3 RX_OVERRUN, bits7:4 zero.
- STATUS write: bit2=1 clears TX_OVERFLOW, bit3=1 clears RX_OVERRUN; other bits ignored.
- DATA write: push `dataOutBus` into TX FIFO; if full, byte dropped and TX_OVERFLOW set (sticky).
- DATA read, access tracking: `access_start` = (addr==DATA) & (previous-cycle addr != DATA); previous address is registered, reset to 0x0000.
  - On `access_start` cycle: `dataInBus` = RX holding register if RX_FULL, else 0x00. At that edge the same value is copied into `read_latch` and RX_FULL clears.
  - Subsequent cycles with addr still DATA: `dataInBus` = `read_latch` (stable for the CPU's sampling cycle).
- RX capture: `rx_valid` with RX_FULL=0 loads holding register, sets RX_FULL. With RX_FULL=1: byte dropped, RX_OVERRUN set.
- Simultaneous `rx_valid` and `access_start` pop: pop takes effect first; new byte loads, RX_FULL stays 1, no overrun.
- TX FIFO: simultaneous push and pop when full is a legal push (no overflow); when empty, push only (pop needs `tx_valid`).

## Timing
- Read latency 0 (combinational); write effect visible on the cycle after the strobe.
- Reset values: `tx_valid`=0, `tx_data`=0x00 (empty FIFO presents 0x00), FIFO pointers 0, RX_FULL=0, flags 0, `read_latch`=0x00, previous address 0x0000; `dataInBus` follows address (e.g. 0xFF unmapped).
- Reset mid-operation discards FIFO contents and held RX byte; RAM contents retained.
- `tx_valid` rises the cycle after the first push into an empty FIFO.
- Flags set and clear on the same edge: set wins.

## Structure
- Package `centurion_bus_pkg`: `MUX_STATUS_ADDR`=16'hF200, `MUX_DATA_ADDR`=16'hF201, status bit index constants, `UNMAPPED_READ`=8'hFF.
- Sub-module `byte_fifo` (parameter DEPTH; push/pop/full/empty/head) for the TX queue; address decode, RAM, RX register and flags stay in the top.

## Test plan
- Write 0x5A to 0x0010, read 0x0010 next cycle -> `dataInBus`=0x5A; read 0x8000 -> 0xFF.
- Write 0x41,0x42,0x43,0x44,0x45 to 0xF201 with `tx_ready`=0 -> STATUS=0x04 (full, overflow); raise `tx_ready` -> 0x41..0x44 emitted in order, then `tx_valid`=0; write 0x04 to 0xF200 -> STATUS=0x02.
- Pulse `rx_valid` with 0x37 -> STATUS bit0=1; hold addr 0xF201 three cycles -> 0x37 on all three, STATUS then 0x02.
- Two `rx_valid` pulses (0x11, 0x22) without read -> holding=0x11, STATUS=0x0B.
- `rx_valid`(0x99) on the `access_start` cycle of an 0xF201 read of 0x55 -> CPU sees 0x55, next access returns 0x99, no overrun.
- Assert `reset` with FIFO holding 2 bytes and RX_FULL=1 -> next cycle `tx_valid`=0, STATUS=0x02, RAM location 0x0010 still 0x5A.

Source files
------------

// File: rtl/centurion_bus_pkg.sv
// Shared constants and types for the CPU6 bus responder.
// Address map, status bit positions and responder state bundle.
package centurion_bus_pkg;

    localparam logic [15:0] MUX_STATUS_ADDR = 16'hF200;
    localparam logic [15:0] MUX_DATA_ADDR   = 16'hF201;
    localparam logic [7:0]  UNMAPPED_READ   = 8'hFF;

    localparam int ST_RX_FULL     = 0;
    localparam int ST_TX_NOT_FULL = 1;
    localparam int ST_TX_OVERFLOW = 2;
    localparam int ST_RX_OVERRUN  = 3;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_STATUS,
        SEL_DATA
    } sel_e;

    typedef struct packed {
        logic        rx_full;
        logic        tx_ovf;
        logic        rx_ovr;
        logic [7:0]  rx_hold;
        logic [7:0]  read_latch;
        logic [15:0] prev_addr;
    } resp_state_t;

    function automatic logic [7:0] status_byte(
        input logic rx_full,
        input logic tx_not_full,
        input logic tx_ovf,
        input logic rx_ovr
    );
        logic [7:0] s;
        s                 = '0;
        s[ST_RX_FULL]     = rx_full;
        s[ST_TX_NOT_FULL] = tx_not_full;
        s[ST_TX_OVERFLOW] = tx_ovf;
        s[ST_RX_OVERRUN]  = rx_ovr;
        return s;
    endfunction

endpackage

// File: rtl/centurion_bus_responder_byte_fifo.sv
// Byte-wide FIFO for the console transmit queue.
// Push while full is accepted only when a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/centurion_bus_responder.sv
// CPU6 bus slave: RAM plus console MUX port (status/data).
// Reads are combinational from the address; writes land on the strobe edge.
module centurion_bus_responder
    import centurion_bus_pkg::*;
#(
    parameter int RAM_WORDS = 4096,
    parameter int TX_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addressBus,
    input  logic [7:0]  dataOutBus,
    input  logic        writeEnBus,
    output logic [7:0]  dataInBus,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [7:0]  mem [RAM_WORDS];
    sel_e        sel;
    resp_state_t st_q, st_d;
    logic        tx_full, tx_empty, tx_push, tx_pop;
    logic        access_start, st_wr;
    logic [7:0]  rx_pick;

    // Address decode into one region select.
    always_comb begin
        sel = SEL_NONE;
        if ({1'b0, addressBus} < 17'(RAM_WORDS)) begin
            sel = SEL_RAM;
        end else if (addressBus == MUX_STATUS_ADDR) begin
            sel = SEL_STATUS;
        end else if (addressBus == MUX_DATA_ADDR) begin
            sel = SEL_DATA;
        end
    end

    assign tx_push      = writeEnBus && (sel == SEL_DATA);
    assign st_wr        = writeEnBus && (sel == SEL_STATUS);
    assign tx_valid     = ~tx_empty;
    assign tx_pop       = tx_valid & tx_ready;
    assign access_start = (sel == SEL_DATA) &&
                          (st_q.prev_addr != MUX_DATA_ADDR);
    assign rx_pick      = st_q.rx_full ? st_q.rx_hold : 8'h00;

    // Read data mux; DATA shows the latched byte after the first cycle.
    always_comb begin
        dataInBus = UNMAPPED_READ;
        unique case (sel)
            SEL_RAM:    dataInBus = mem[addressBus[AW-1:0]];
            SEL_STATUS: dataInBus = status_byte(st_q.rx_full, ~tx_full,
                                                st_q.tx_ovf, st_q.rx_ovr);
            SEL_DATA:   dataInBus = access_start ? rx_pick
                                                 : st_q.read_latch;
            default:    dataInBus = UNMAPPED_READ;
        endcase
    end

    // RX holding, read latch and sticky flags; a set beats a clear.
    always_comb begin
        st_d           = st_q;
        st_d.prev_addr = addressBus;
        if (access_start) begin
            st_d.read_latch = rx_pick;
            st_d.rx_full    = 1'b0;
        end
        if (st_wr && dataOutBus[ST_TX_OVERFLOW]) begin
            st_d.tx_ovf = 1'b0;
        end
        if (st_wr && dataOutBus[ST_RX_OVERRUN]) begin
            st_d.rx_ovr = 1'b0;
        end
        if (tx_push && tx_full && !tx_pop) begin
            st_d.tx_ovf = 1'b1;
        end
        if (rx_valid) begin
            if (!st_q.rx_full || access_start) begin
                st_d.rx_hold = rx_data;
                st_d.rx_full = 1'b1;
            end else begin
                st_d.rx_ovr = 1'b1;
            end
        end
    end

    // Responder state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (writeEnBus && (sel == SEL_RAM)) begin
            mem[addressBus[AW-1:0]] <= dataOutBus;
        end
    end

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (tx_push),
        .data_i  (dataOutBus),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_data)
    );

endmodule

// File: tb/tb_centurion_bus_responder.sv
// Bench for centurion_bus_responder: directed plan plus random bus traffic.
// A behavioural model predicts each cycle; a negedge monitor compares.
module tb_centurion_bus_responder;

    localparam int RW = 4096;
    localparam int TD = 4;
    localparam logic [15:0] ST = 16'hF200;
    localparam logic [15:0] DT = 16'hF201;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] addressBus;
    logic [7:0]  dataOutBus;
    logic        writeEnBus;
    logic [7:0]  dataInBus;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;

    centurion_bus_responder #(
        .RAM_WORDS (RW),
        .TX_DEPTH  (TD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addressBus (addressBus),
        .dataOutBus (dataOutBus),
        .writeEnBus (writeEnBus),
        .dataInBus  (dataInBus),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        bit         dk;
        logic       txv;
        logic [7:0] txd;
    } exp_t;

    exp_t       chkq[$];
    logic [7:0] exp_tx[$];
    int         total = 0;
    int         bad = 0;

    logic [7:0] mref [int];
    logic [7:0] mtx[$];
    bit         m_full, m_ovf, m_ovr;
    logic [7:0] m_hold, m_latch;
    logic [15:0] m_prev;

    task automatic check(input string n, input logic [7:0] act,
                         input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", n, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mtx.delete();
        exp_tx.delete();
        m_full = 0; m_ovf = 0; m_ovr = 0;
        m_hold = 0; m_latch = 0; m_prev = 0;
    endtask

    // One bus cycle of the device as described by the port's rules.
    task automatic model(input logic [15:0] a, input logic [7:0] wd,
                         input bit we, input bit rxv, input logic [7:0] rxd,
                         input bit txr, output exp_t e);
        bit start;
        start = (a == DT) && (m_prev != DT);
        e.dk  = 1;
        e.txv = (mtx.size() != 0);
        e.txd = e.txv ? mtx[0] : 8'h00;
        if (int'(a) < RW) begin
            if (mref.exists(int'(a))) e.d = mref[int'(a)];
            else begin e.d = 0; e.dk = 0; end
        end else if (a == ST) begin
            e.d = {4'b0, m_ovr, m_ovf, (mtx.size() < TD), m_full};
        end else if (a == DT) begin
            e.d = start ? (m_full ? m_hold : 8'h00) : m_latch;
        end else begin
            e.d = 8'hFF;
        end
        if (we && a == ST && wd[2]) m_ovf = 0;
        if (we && a == ST && wd[3]) m_ovr = 0;
        if (txr && mtx.size() > 0) void'(mtx.pop_front());
        if (we && a == DT) begin
            if (mtx.size() < TD) begin
                mtx.push_back(wd);
                exp_tx.push_back(wd);
            end else begin
                m_ovf = 1;
            end
        end
        if (start) begin
            m_latch = e.d;
            m_full  = 0;
        end
        if (rxv) begin
            if (!m_full) begin m_hold = rxd; m_full = 1; end
            else m_ovr = 1;
        end
        if (we && int'(a) < RW) mref[int'(a)] = wd;
        m_prev = a;
    endtask

    task automatic cycle(input logic [15:0] a, input logic [7:0] wd = 0,
                         input bit we = 0, input bit rxv = 0,
                         input logic [7:0] rxd = 0, input bit txr = 0);
        exp_t e;
        @(posedge clock); #1;
        reset = 0; addressBus = a; dataOutBus = wd; writeEnBus = we;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        model(a, wd, we, rxv, rxd, txr, e);
        chkq.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1; addressBus = 16'h8000; dataOutBus = 0; writeEnBus = 0;
        rx_valid = 0; rx_data = 0; tx_ready = 0;
        model_reset();
    endtask

    task automatic anchor(input string n, input logic [7:0] expv);
        @(negedge clock); #1;
        check(n, dataInBus, expv);
    endtask

    // Monitor: per-cycle predictions and the transmit byte scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (chkq.size() > 0) begin
            e = chkq.pop_front();
            if (e.dk) check("dataInBus", dataInBus, e.d);
            check("tx_valid", {7'b0, tx_valid}, {7'b0, e.txv});
            check("tx_data", tx_data, e.txd);
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1 && reset === 1'b0) begin
            if (exp_tx.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_byte: got %02h want none", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_tx.pop_front());
            end
        end
    end

    function automatic logic [15:0] unmapped_addr();
        if ($urandom_range(0, 1) == 0)
            return 16'($urandom_range(16'h1000, 16'hF1FF));
        return 16'($urandom_range(16'hF202, 16'hFFFF));
    endfunction

    initial begin
        do_reset();
        do_reset();
        cycle(16'h8000);           anchor("unmapped_rst", 8'hFF);
        cycle(ST);                 anchor("status_rst", 8'h02);
        for (int i = 0; i < 32; i++) cycle(16'(i), 8'($urandom), 1);
        cycle(16'h0010, 8'h5A, 1);
        cycle(16'h0010);           anchor("ram_5a", 8'h5A);
        cycle(16'h8000);           anchor("unmapped_8000", 8'hFF);

        for (int i = 0; i < 5; i++) cycle(DT, 8'(8'h41 + i), 1);
        cycle(ST);                 anchor("status_ovf", 8'h04);
        repeat (6) cycle(16'h8000, 0, 0, 0, 0, 1);
        cycle(ST, 8'h04, 1);
        cycle(ST);                 anchor("status_clr", 8'h02);

        cycle(16'h8000, 0, 0, 1, 8'h37);
        cycle(ST);                 anchor("status_rx", 8'h03);
        for (int i = 0; i < 3; i++) begin
            cycle(DT);             anchor("rx_hold3", 8'h37);
        end
        cycle(ST);                 anchor("status_rx_done", 8'h02);

        cycle(16'h8000, 0, 0, 1, 8'h11);
        cycle(16'h8000, 0, 0, 1, 8'h22);
        cycle(ST);                 anchor("status_ovr", 8'h0B);
        cycle(DT);                 anchor("rx_first", 8'h11);
        cycle(ST, 8'h08, 1);

        cycle(16'h8000, 0, 0, 1, 8'h55);
        cycle(DT, 0, 0, 1, 8'h99); anchor("rx_race_old", 8'h55);
        cycle(16'h8000);
        cycle(DT);                 anchor("rx_race_new", 8'h99);
        cycle(ST);                 anchor("rx_race_st", 8'h02);

        cycle(DT, 8'hA1, 1);
        cycle(DT, 8'hA2, 1);
        cycle(16'h8000, 0, 0, 1, 8'h66);
        do_reset();
        cycle(ST);                 anchor("status_mid_rst", 8'h02);
        cycle(16'h0010);           anchor("ram_kept", 8'h5A);

        for (int op = 0; op < 400; op++) begin
            bit         txr, rxv;
            logic [7:0] rd, wd;
            int         k;
            txr = ($urandom_range(0, 2) != 0);
            rxv = ($urandom_range(0, 5) == 0);
            rd  = 8'($urandom);
            wd  = 8'($urandom);
            k   = $urandom_range(0, 7);
            case (k)
                0: cycle(16'($urandom_range(0, 31)), wd, 1, rxv, rd, txr);
                1: cycle(16'($urandom_range(0, 31)), 0, 0, rxv, rd, txr);
                2: cycle(ST, 0, 0, rxv, rd, txr);
                3: begin
                    int n;
                    n = $urandom_range(1, 3);
                    for (int j = 0; j < n; j++)
                        cycle(DT, 0, 0, ($urandom_range(0, 3) == 0),
                              8'($urandom), txr);
                end
                4: cycle(DT, wd, 1, rxv, rd, txr);
                5: cycle(ST, wd, 1, rxv, rd, txr);
                6: cycle(unmapped_addr(), 0, 0, rxv, rd, txr);
                default: cycle(unmapped_addr(), wd, 1, rxv, rd, txr);
            endcase
        end

        repeat (TD + 4) cycle(16'h8000, 0, 0, 0, 0, 1);
        @(negedge clock); #1;
        total++;
        if (exp_tx.size() != 0) begin
            bad++;
            $display("FAIL tx_drain: got %0d left want 0", exp_tx.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
